// File: rtl/axi4_seq_fetch.sv
// axi4_seq_fetch: AXI4-lite read master that fetches packed 2-bit bases
// into a small word FIFO and unpacks them into a per-base stream.
module axi4_seq_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] num_words,
    output logic             busy,
    output logic             done,
    output logic             mem_axi_arvalid,
    input  logic             mem_axi_arready,
    output logic [31:0]      mem_axi_araddr,
    output logic [2:0]       mem_axi_arprot,
    input  logic             mem_axi_rvalid,
    output logic             mem_axi_rready,
    input  logic [31:0]      mem_axi_rdata,
    output logic             base_valid,
    input  logic             base_ready,
    output logic [1:0]       base,
    output logic             base_last
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] LP_DEPTH = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_wleft;
    logic             r_resv;
    logic             r_rwait;
    logic             r_busy;
    logic             r_done;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [31:0]      r_word;
    logic [3:0]       r_idx;
    logic             r_bvalid;
    logic             r_cur_last;

    logic             w_accept;
    logic             w_zero;
    logic             w_arhs;
    logic             w_push;
    logic             w_pop;
    logic             w_bhs;
    logic             w_wend;
    logic             w_lasths;
    logic             w_bv_nxt;
    logic             w_free;
    logic             w_free_nxt;
    logic [OW-1:0]    w_occ;
    logic [OW-1:0]    w_cnt_nxt;
    logic [OW-1:0]    w_occ_nxt;
    logic             w_unused;

    assign w_accept = (r_state == S_IDLE) && !r_busy && start
                      && (num_words != '0);
    assign w_zero   = (r_state == S_IDLE) && !r_busy && start
                      && (num_words == '0);
    assign w_arhs   = mem_axi_arvalid && mem_axi_arready;
    assign w_push   = mem_axi_rvalid && mem_axi_rready;
    assign w_bhs    = r_bvalid && base_ready;
    assign w_wend   = w_bhs && (r_idx == 4'hF);
    assign w_lasths = w_bhs && base_last;
    assign w_pop    = (r_count != '0) && (!r_bvalid || w_wend);
    assign w_bv_nxt = w_pop || (r_bvalid && !w_wend);

    // Occupancy counts the word held by the unpacker and the reserved slot
    assign w_occ      = OW'(r_count) + OW'(r_bvalid) + OW'(r_resv);
    assign w_cnt_nxt  = OW'(r_count) + OW'(w_push) - OW'(w_pop);
    assign w_occ_nxt  = w_cnt_nxt + OW'(w_bv_nxt);
    assign w_free     = w_occ < LP_DEPTH;
    assign w_free_nxt = w_occ_nxt < LP_DEPTH;

    assign busy           = r_busy;
    assign done           = r_done;
    assign mem_axi_araddr = r_addr;
    assign mem_axi_arprot = 3'b000;
    assign base_valid     = r_bvalid;
    assign base           = r_word[{r_idx, 1'b0} +: 2];
    assign base_last      = r_bvalid && r_cur_last && (r_idx == 4'hF);
    assign w_unused       = ^base_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if ((w_accept || r_busy) && w_free) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (w_arhs) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_rwait) begin
                    if (w_free) w_state_nxt = S_ADDR;
                end else if (w_push) begin
                    if (r_rem == '0)     w_state_nxt = S_DRAIN;
                    else if (w_free_nxt) w_state_nxt = S_ADDR;
                end
            end
            S_DRAIN: begin
                if (w_lasths) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // AXI channel outputs decoded from state
    always_comb begin
        mem_axi_arvalid = (r_state == S_ADDR);
        mem_axi_rready  = (r_state == S_DATA) && !r_rwait;
    end

    // Address, word counters, reservation and status flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_resv  <= 1'b0;
            r_rwait <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= {base_addr[31:2], 2'b00};
                r_rem  <= num_words;
            end else if (w_arhs) begin
                r_addr <= r_addr + 32'd4;
                r_rem  <= r_rem - LEN_W'(1);
            end
            if (w_arhs)      r_resv <= 1'b1;
            else if (w_push) r_resv <= 1'b0;
            r_rwait <= (w_state_nxt == S_DATA) && (r_rwait || w_push);
            if (w_accept)      r_busy <= 1'b1;
            else if (w_lasths) r_busy <= 1'b0;
            r_done <= w_zero || ((r_state == S_DRAIN) && w_lasths);
        end
    end

    // Word FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= mem_axi_rdata;
    end

    // Word FIFO pointers and fill count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_cnt_nxt[CW-1:0];
        end
    end

    // Unpacker: holds one word and steps through its 16 bases LSB first
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_word     <= '0;
            r_idx      <= '0;
            r_bvalid   <= 1'b0;
            r_cur_last <= 1'b0;
            r_wleft    <= '0;
        end else begin
            r_bvalid <= w_bv_nxt;
            if (w_pop) begin
                r_word     <= r_mem[r_rptr];
                r_idx      <= '0;
                r_cur_last <= (r_wleft == LEN_W'(1));
            end else if (w_bhs && !w_wend) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_accept)   r_wleft <= num_words;
            else if (w_pop) r_wleft <= r_wleft - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_axi4_seq_fetch.sv
// tb_axi4_seq_fetch: table-driven and randomized bench for axi4_seq_fetch
// with a behavioural memory slave and a stream reference model.
module tb_axi4_seq_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        busy;
    logic        done;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic        base_valid;
    logic        base_ready = 1'b0;
    logic [1:0]  base;
    logic        base_last;

    axi4_seq_fetch #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
        .mem_axi_rdata(rdata),
        .base_valid(base_valid), .base_ready(base_ready),
        .base(base), .base_last(base_last)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    int rmode = 0;
    bit arr_always = 1'b1;
    bit fixed_data = 1'b0;

    logic [31:0] q_ar[$];
    logic [1:0]  q_base[$];
    bit          q_last[$];
    int m_done, m_outst, m_viol, m_gaps, m_arv_seen, m_busy_seen;
    int m_r_cyc, m_bv_cyc, cyc;
    bit m_in_stream;

    bit          f_ar, f_r;
    logic [31:0] f_addr;
    bit          s_pend;
    logic [31:0] s_addr;
    int          s_lat;

    typedef struct {
        logic [31:0] addr;
        int          n;
        int          rm;
        bit          arr1;
        bit          fixd;
        bit          gap;
        logic [31:0] exp_first;
        int          exp_bases;
    } vec_t;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (fixed_data) return 32'hE4E4_E4E4;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        q_ar.delete();
        q_base.delete();
        q_last.delete();
        m_done = 0; m_outst = 0; m_viol = 0; m_gaps = 0;
        m_arv_seen = 0; m_busy_seen = 0;
        m_r_cyc = -1; m_bv_cyc = -1; m_in_stream = 1'b0;
    endtask

    // Monitor at negedge, memory slave and stream sink after posedge
    always begin
        @(negedge clk);
        cyc++;
        f_ar = 1'b0;
        f_r  = 1'b0;
        if (resetn) begin
            f_ar = arvalid && arready;
            f_r  = rvalid && rready;
            f_addr = araddr;
            if (f_ar) begin
                q_ar.push_back(araddr);
                m_outst++;
                if (m_outst > 1) m_viol++;
            end
            if (f_r) begin
                m_outst--;
                if (m_r_cyc < 0) m_r_cyc = cyc;
            end
            if (base_valid && m_bv_cyc < 0) m_bv_cyc = cyc;
            if (m_in_stream && !base_valid) m_gaps++;
            if (base_valid) m_in_stream = 1'b1;
            if (base_valid && base_ready) begin
                q_base.push_back(base);
                q_last.push_back(base_last);
                if (base_last) m_in_stream = 1'b0;
            end
            if (done) m_done++;
            if (arvalid) m_arv_seen++;
            if (busy) m_busy_seen++;
        end
        @(posedge clk);
        #1;
        if (!resetn) begin
            rvalid  = 1'b0;
            arready = 1'b0;
            s_pend  = 1'b0;
        end else begin
            if (f_r) begin
                rvalid = 1'b0;
                s_pend = 1'b0;
            end
            if (f_ar) begin
                s_pend = 1'b1;
                s_addr = f_addr;
                s_lat  = int'($urandom_range(0, 3));
            end
            if (s_pend && !rvalid) begin
                if (s_lat == 0) begin
                    rvalid = 1'b1;
                    rdata  = memf(s_addr);
                end else begin
                    s_lat--;
                end
            end
            arready = arr_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        case (rmode)
            0:       base_ready = 1'b1;
            1:       base_ready = $urandom_range(0, 1) != 0;
            default: base_ready = 1'b0;
        endcase
    end

    task automatic kick(input logic [31:0] a, input int n);
        base_addr = a;
        num_words = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (m_done == 0 && k < budget) begin
            tick();
            k++;
        end
        tick(2);
    endtask

    task automatic check_xfer(input string name, input logic [31:0] a,
                              input int n, input bit gap_chk);
        logic [31:0] ea;
        logic [31:0] w;
        int bad_a = 0;
        int bad_b = 0;
        int nlast = 0;
        int lidx = -1;
        ea = {a[31:2], 2'b00};
        chk($sformatf("%s ar_cnt", name), q_ar.size(), n);
        for (int i = 0; i < n && i < q_ar.size(); i++)
            if (q_ar[i] !== ea + 32'(4 * i)) bad_a++;
        chk($sformatf("%s araddr_seq", name), bad_a, 0);
        chk($sformatf("%s base_cnt", name), q_base.size(), 16 * n);
        for (int i = 0; i < q_base.size() && i < 16 * n; i++) begin
            w = memf(ea + 32'(4 * (i / 16)));
            if (q_base[i] !== 2'((w >> (2 * (i % 16))) & 32'd3)) bad_b++;
        end
        chk($sformatf("%s base_seq", name), bad_b, 0);
        for (int i = 0; i < q_last.size(); i++)
            if (q_last[i]) begin
                nlast++;
                lidx = i;
            end
        chk($sformatf("%s last_cnt", name), nlast, 1);
        chk($sformatf("%s last_pos", name), lidx, 16 * n - 1);
        chk($sformatf("%s done_cnt", name), m_done, 1);
        chk($sformatf("%s outstanding", name), m_viol, 0);
        chk($sformatf("%s busy_end", name), {busy, done}, 2'b00);
        chk($sformatf("%s r_to_bv", name), m_bv_cyc - m_r_cyc, 2);
        if (gap_chk) chk($sformatf("%s gaps", name), m_gaps, 0);
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{32'h4000_0000, 1, 0, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 16};
        vt[1] = '{32'h4000_0013, 3, 0, 1'b1, 1'b0, 1'b1, 32'h4000_0010, 48};
        vt[2] = '{32'h4000_0100, 5, 1, 1'b0, 1'b0, 1'b0, 32'h4000_0100, 80};
        vt[3] = '{32'hFFFF_FFFA, 4, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 64};

        clr_mon();
        tick(3);
        chk("reset_outs",
            {busy, done, arvalid, araddr, arprot, rready,
             base_valid, base, base_last}, '0);
        resetn = 1'b1;
        tick(2);

        foreach (vt[i]) begin
            clr_mon();
            rmode = vt[i].rm;
            arr_always = vt[i].arr1;
            fixed_data = vt[i].fixd;
            tick();
            kick(vt[i].addr, vt[i].n);
            chk($sformatf("v%0d start_lat", i), {arvalid, busy}, 2'b11);
            wait_done(3000);
            chk($sformatf("v%0d first_ar", i), q_ar.size() > 0 ? q_ar[0] : 0,
                vt[i].exp_first);
            chk($sformatf("v%0d nbases", i), q_base.size(), vt[i].exp_bases);
            check_xfer($sformatf("v%0d", i), vt[i].addr, vt[i].n, vt[i].gap);
        end
        fixed_data = 1'b0;

        for (int r = 0; r < 6; r++) begin
            logic [31:0] a;
            int n;
            clr_mon();
            a = $urandom;
            n = int'($urandom_range(1, 6));
            rmode = int'($urandom_range(0, 1));
            arr_always = $urandom_range(0, 1) != 0;
            tick();
            kick(a, n);
            wait_done(3000);
            check_xfer($sformatf("rnd%0d", r), a, n,
                       rmode == 0 && arr_always);
        end

        clr_mon();
        rmode = 0;
        arr_always = 1'b1;
        tick();
        kick(32'h4000_0000, 0);
        chk("zero done", {done, busy}, 2'b10);
        tick();
        chk("zero done_pulse", done, 1'b0);
        tick(5);
        chk("zero no_ar", m_arv_seen + q_ar.size(), 0);
        chk("zero no_busy", m_busy_seen, 0);

        clr_mon();
        rmode = 2;
        tick();
        kick(32'h4000_0200, 8);
        tick(200);
        chk("bp ar_cnt", q_ar.size(), 4);
        chk("bp arvalid", arvalid, 1'b0);
        chk("bp busy_valid", {busy, base_valid}, 2'b11);
        chk("bp no_bases", q_base.size(), 0);
        rmode = 0;
        wait_done(3000);
        check_xfer("bp", 32'h4000_0200, 8, 1'b0);

        clr_mon();
        rmode = 1;
        tick();
        kick(32'h4000_0400, 4);
        tick(10);
        base_addr = 32'h5000_0000;
        num_words = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3000);
        check_xfer("busy_start", 32'h4000_0400, 4, 1'b0);

        clr_mon();
        rmode = 0;
        tick();
        kick(32'h4000_0600, 4);
        for (int k = 0; k < 200 && q_ar.size() < 2; k++) tick();
        chk("rst reached", q_ar.size(), 2);
        resetn = 1'b0;
        #1;
        chk("rst outs",
            {busy, done, arvalid, araddr, rready,
             base_valid, base, base_last}, '0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        clr_mon();
        kick(32'h4000_0700, 2);
        wait_done(3000);
        check_xfer("post_rst", 32'h4000_0700, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_seq_fetch.md
Name: axi4_seq_fetch

Overview:
- AXI4-lite read master that sits directly upstream of the simulation memory peripheral (`axi4_mem_periph`).
- Fetches a block of packed 2-bit nucleotide words from memory and unpacks them into a per-base valid/ready stream for the alignment core.
- One read is outstanding at a time. A small word FIFO decouples memory latency from the consumer.

Parameters:
- FIFO_DEPTH, 4, word FIFO depth; power of two, minimum 2.
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  32  byte address of the first word; bits [1:0] are ignored (forced to 0).
- num_words  in  LEN_W  number of 32-bit words to fetch.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at completion.
- mem_axi_arvalid  out  1  read-address valid.
- mem_axi_arready  in  1  read-address ready.
- mem_axi_araddr  out  32  read address.
- mem_axi_arprot  out  3  constant 3'b000 (data access).
- mem_axi_rvalid  in  1  read-data valid.
- mem_axi_rready  out  1  read-data ready.
- mem_axi_rdata  in  32  read data.
- base_valid  out  1  stream valid.
- base_ready  in  1  stream ready.
- base  out  2  nucleotide code (A=0, C=1, G=2, T=3).
- base_last  out  1  marks the final base of the block.

Behaviour:
- Reset values: busy=0, done=0, arvalid=0, araddr=0, rready=0, base_valid=0, base=0, base_last=0. FIFO is empty, state is IDLE.
- State machine states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - start=1 with num_words=0: done pulses in the next cycle, busy stays 0, no AR is issued.
  - start=1 with num_words>0: latch {base_addr[31:2],2'b00} and num_words, then set busy=1.
  - Go to ADDR once the FIFO has a free slot (free slots counted as empty entries minus reserved).
- ADDR:
  - arvalid=1 with a stable araddr until the cycle where arvalid&arready.
  - On that handshake: reserve one FIFO slot, araddr+=4 (wraps modulo 2^32), remaining-=1, go to DATA.
- DATA:
  - rready=1; it is always safe because the slot is already reserved.
  - On rvalid&rready: push rdata into the FIFO and release the reservation.
  - If remaining>0 and a free slot exists, go to ADDR; if remaining>0 and no slot, wait in DATA with rready=0 until a slot frees. Otherwise go to DRAIN.
  - At most one AR is ever outstanding.
- Unpacker:
  - Holds the current word and a 4-bit base index.
  - When idle with the FIFO non-empty, it pops a word and asserts base_valid on the following cycle.
  - Emits bases LSB first: index k outputs word[2k+1:2k], for k=0..15.
  - Advances only on base_valid&base_ready. base and base_last are held stable while valid&!ready.
  - After k=15 it pops the next word in the same cycle if one is available, so the stream has no bubble.
- base_last=1 only at k=15 of the num_words-th word.
- DRAIN: wait until the handshake of the base with base_last=1; done pulses in the next cycle, busy drops in the same cycle as done, then go to IDLE.
- Latency, no backpressure: start accepted at cycle 0 → arvalid at cycle 1. R handshake at cycle t → base_valid at cycle t+2.
- start while busy is ignored.
- The AXI write channel is not generated; the top level ties awvalid/wvalid low for this master.
- Reset mid-operation clears all state immediately. The system resets the memory peripheral together with this block; a response still in flight is not tracked.
- No error path: the memory peripheral terminates simulation on out-of-bounds accesses.

Test Plan:
- Single word: base_addr=0x4000_0000, num_words=1, memory=0xE4E4E4E4, base_ready=1 → one AR at 0x4000_0000; bases 0,1,2,3 repeated 4×; base_last only on the 16th base; done pulses once.
- Multi-word and alignment: base_addr=0x4000_0013, num_words=3 → araddr sequence 0x4000_0010, 0x4000_0014, 0x4000_0018; 48 bases; no gap in base_valid between words.
- Backpressure: num_words=8, FIFO_DEPTH=4, base_ready held low for 200 cycles → exactly 4 AR handshakes, FIFO full, no further arvalid; then ready=1 → all 128 bases delivered in order, done once.
- Zero length: num_words=0 → done at cycle 1, busy never high, arvalid never high.
- start while busy: a second start with a different base_addr during a transfer → ignored; araddr sequence unchanged.
- Reset mid-transfer: resetn low during DATA of word 2 → all outputs return to reset values asynchronously; a new start afterwards completes normally.
